// File: rtl/uart_fifo_px.sv
// Full-duplex UART with 16x-oversampled receiver, configurable frame format
// and independent first-word-fall-through RX and TX FIFOs. In loopback mode
// every good received byte is pushed into the TX FIFO instead of the RX FIFO.

module uart_fifo_px_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    // a push on a full FIFO only lands when a pop frees the head slot
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // storage array, written on accepted pushes
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_fifo_px #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic                          tx,
    input  logic                          loopback,
    input  logic                          rx_rd,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    input  logic                          tx_wr,
    input  logic [DATA_BITS-1:0]          tx_wdata,
    output logic                          tx_full,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    output logic                          tx_busy,
    output logic                          rx_done,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow
);
    localparam int BAUD_DIV = CLK_FREQ / (BAUD * 16);
    localparam int DIV_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;
    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;

    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic                 rx_meta;
    logic                 rx_sync;

    rx_state_t            rx_state;
    logic [3:0]           rx_ticks;
    logic [2:0]           rx_bits;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_pbit;
    logic                 rx_stop_samp;
    logic                 par_ok;
    logic                 rx_good;

    tx_state_t            tx_state;
    logic [3:0]           tx_ticks;
    logic [2:0]           tx_bits;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_pop;

    logic                 rxf_push;
    logic                 rxf_full;
    logic                 txf_push;
    logic [DATA_BITS-1:0] txf_wdata;
    logic [DATA_BITS-1:0] txf_head;
    logic                 txf_empty;

    assign tick = (div_cnt == DIV_W'(BAUD_DIV - 1));

    // free-running oversample divider shared by both directions
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // receive FSM: mid-start validation, then one sample per 16 ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= R_IDLE;
            rx_ticks <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_pbit  <= 1'b0;
        end else begin
            case (rx_state)
                R_IDLE: begin
                    rx_ticks <= '0;
                    if (!rx_sync) rx_state <= R_START;
                end
                R_START: if (tick) begin
                    if (rx_ticks == 4'd7) begin
                        rx_ticks <= '0;
                        rx_bits  <= '0;
                        rx_state <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        rx_ticks <= rx_ticks + 1'b1;
                    end
                end
                R_DATA: if (tick) begin
                    rx_ticks <= rx_ticks + 1'b1;
                    if (rx_ticks == 4'd15) begin
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_bits == 3'(DATA_BITS - 1))
                            rx_state <= (PARITY != 0) ? R_PARITY : R_STOP;
                        else
                            rx_bits <= rx_bits + 1'b1;
                    end
                end
                R_PARITY: if (tick) begin
                    rx_ticks <= rx_ticks + 1'b1;
                    if (rx_ticks == 4'd15) begin
                        rx_pbit  <= rx_sync;
                        rx_state <= R_STOP;
                    end
                end
                R_STOP: if (tick) begin
                    rx_ticks <= rx_ticks + 1'b1;
                    if (rx_ticks == 4'd15) rx_state <= R_IDLE;
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // parity check of the assembled frame
    always_comb begin
        par_ok = 1'b1;
        if (PARITY == 1)      par_ok = ^{rx_shift, rx_pbit};
        else if (PARITY == 2) par_ok = ~^{rx_shift, rx_pbit};
    end

    assign rx_stop_samp = (rx_state == R_STOP) && tick && (rx_ticks == 4'd15);
    assign rx_good      = rx_stop_samp && rx_sync && par_ok;

    assign rxf_push  = rx_good && !loopback;
    assign txf_push  = loopback ? rx_good  : tx_wr;
    assign txf_wdata = loopback ? rx_shift : tx_wdata;

    // status pulses, aligned with the FIFO write of the frame they report
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rx_done    <= rx_good;
            frame_err  <= rx_stop_samp && !rx_sync;
            parity_err <= rx_stop_samp && rx_sync && !par_ok;
            overflow   <= (rxf_push && rxf_full && !rx_rd) ||
                          (loopback && rx_good && tx_full && !tx_pop);
        end
    end

    uart_fifo_px_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rxf_push),
        .wdata (rx_shift),
        .pop   (rx_rd),
        .rdata (rx_data),
        .empty (rx_empty),
        .full  (rxf_full),
        .count (rx_count)
    );

    uart_fifo_px_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (txf_push),
        .wdata (txf_wdata),
        .pop   (tx_pop),
        .rdata (txf_head),
        .empty (txf_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    assign tx_pop  = (tx_state == T_IDLE) && !txf_empty;
    assign tx_busy = (tx_state != T_IDLE);

    // transmit FSM with registered line output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= T_IDLE;
            tx_ticks <= '0;
            tx_bits  <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    tx <= 1'b1;
                    if (!txf_empty) begin
                        tx_shift <= txf_head;
                        tx_par   <= (PARITY == 1) ? ~^txf_head : ^txf_head;
                        tx_ticks <= '0;
                        tx       <= 1'b0;
                        tx_state <= T_START;
                    end
                end
                T_START: if (tick) begin
                    tx_ticks <= tx_ticks + 1'b1;
                    if (tx_ticks == 4'd15) begin
                        tx_bits  <= '0;
                        tx       <= tx_shift[0];
                        tx_state <= T_DATA;
                    end
                end
                T_DATA: if (tick) begin
                    tx_ticks <= tx_ticks + 1'b1;
                    if (tx_ticks == 4'd15) begin
                        if (tx_bits == 3'(DATA_BITS - 1)) begin
                            tx_bits <= '0;
                            if (PARITY != 0) begin
                                tx       <= tx_par;
                                tx_state <= T_PARITY;
                            end else begin
                                tx       <= 1'b1;
                                tx_state <= T_STOP;
                            end
                        end else begin
                            tx_bits  <= tx_bits + 1'b1;
                            tx_shift <= tx_shift >> 1;
                            tx       <= tx_shift[1];
                        end
                    end
                end
                T_PARITY: if (tick) begin
                    tx_ticks <= tx_ticks + 1'b1;
                    if (tx_ticks == 4'd15) begin
                        tx       <= 1'b1;
                        tx_state <= T_STOP;
                    end
                end
                T_STOP: if (tick) begin
                    tx_ticks <= tx_ticks + 1'b1;
                    if (tx_ticks == 4'd15) begin
                        if (tx_bits == 3'(STOP_BITS - 1)) tx_state <= T_IDLE;
                        else                              tx_bits  <= tx_bits + 1'b1;
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo_px.sv
// Self-checking bench for uart_fifo_px. Two instances run at 4 clk per tick
// (64 clk per bit): A = 8N1 with a 4-deep FIFO, B = 8E2 with a 16-deep FIFO.

module tb_uart_fifo_px;
    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic       rx_a = 1'b1, loopback_a = 1'b0, rx_rd_a = 1'b0, tx_wr_a = 1'b0;
    logic [7:0] tx_wdata_a = '0;
    logic       tx_a, rx_empty_a, tx_full_a, tx_busy_a;
    logic       rx_done_a, frame_err_a, parity_err_a, overflow_a;
    logic [7:0] rx_data_a;
    logic [2:0] rx_count_a, tx_count_a;

    logic       rx_b = 1'b1;
    logic       tx_b, rx_empty_b, tx_full_b, tx_busy_b;
    logic       rx_done_b, frame_err_b, parity_err_b, overflow_b;
    logic [7:0] rx_data_b;
    logic [4:0] rx_count_b, tx_count_b;

    int n_done_a = 0, n_ferr_a = 0, n_perr_a = 0, n_ovf_a = 0;
    int n_done_b = 0, n_ferr_b = 0, n_perr_b = 0, n_ovf_b = 0;

    uart_fifo_px #(.CLK_FREQ(1_600_000), .BAUD(25_000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a), .loopback(loopback_a),
        .rx_rd(rx_rd_a), .rx_data(rx_data_a), .rx_empty(rx_empty_a),
        .rx_count(rx_count_a), .tx_wr(tx_wr_a), .tx_wdata(tx_wdata_a),
        .tx_full(tx_full_a), .tx_count(tx_count_a), .tx_busy(tx_busy_a),
        .rx_done(rx_done_a), .frame_err(frame_err_a),
        .parity_err(parity_err_a), .overflow(overflow_a)
    );

    uart_fifo_px #(.CLK_FREQ(1_600_000), .BAUD(25_000), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .tx(tx_b), .loopback(1'b0),
        .rx_rd(1'b0), .rx_data(rx_data_b), .rx_empty(rx_empty_b),
        .rx_count(rx_count_b), .tx_wr(1'b0), .tx_wdata(8'h00),
        .tx_full(tx_full_b), .tx_count(tx_count_b), .tx_busy(tx_busy_b),
        .rx_done(rx_done_b), .frame_err(frame_err_b),
        .parity_err(parity_err_b), .overflow(overflow_b)
    );

    always #5 clk = ~clk;

    // cycle counter and pulse tallies
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_done_a)    n_done_a <= n_done_a + 1;
        if (frame_err_a)  n_ferr_a <= n_ferr_a + 1;
        if (parity_err_a) n_perr_a <= n_perr_a + 1;
        if (overflow_a)   n_ovf_a  <= n_ovf_a + 1;
        if (rx_done_b)    n_done_b <= n_done_b + 1;
        if (frame_err_b)  n_ferr_b <= n_ferr_b + 1;
        if (parity_err_b) n_perr_b <= n_perr_b + 1;
        if (overflow_b)   n_ovf_b  <= n_ovf_b + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input int n);
        @(negedge clk);
        if (sel) rx_b = v; else rx_a = v;
        repeat (n - 1) @(negedge clk);
    endtask

    // A low stop bit is released 3/4 into the bit so the receiver's restart
    // on the still-low line resolves as a glitch rather than a phantom frame.
    task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                              input bit pbit, input bit stop);
        drive(sel, 1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(sel, d[i], BIT);
        if (has_par) drive(sel, pbit, BIT);
        if (stop) drive(sel, 1'b1, BIT);
        else begin
            drive(sel, 1'b0, 48);
            drive(sel, 1'b1, 16);
        end
        drive(sel, 1'b1, BIT);
    endtask

    task automatic pop_a(input logic [7:0] exp);
        @(negedge clk);
        chk("rx_empty_before_pop", rx_empty_a, 1'b0);
        chk("rx_data", rx_data_a, exp);
        rx_rd_a = 1'b1;
        @(negedge clk);
        rx_rd_a = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(posedge clk);
        #1;
    endtask

    // Watches tx_a for nfr 8N1 frames, sampled at bit centres from the first
    // falling edge; frames are expected contiguous at 640 clk spacing.
    task automatic check_tx(input int nfr, input logic [63:0] bytes,
                            input bit chk_cnt, input int cnt0);
        int f;
        int guard;
        logic [7:0] b;
        guard = 0;
        @(posedge clk); #1;
        while (tx_a !== 1'b0 && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (tx_a !== 1'b0) begin
            chk("tx_start_timeout", {31'b0, tx_a}, 32'h0);
            return;
        end
        f = cyc;
        for (int j = 0; j < nfr; j++) begin
            b = bytes[8*j +: 8];
            for (int k = 0; k < 10; k++) begin
                wait_until(f + 640*j + BIT*k + 32);
                chk("tx_bit", tx_a, (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1]);
                chk("tx_busy_in_frame", tx_busy_a, 1'b1);
                if (chk_cnt && k == 0) chk("tx_count_at_start", tx_count_a, cnt0 - j);
            end
        end
        wait_until(f + 640*nfr + 32);
        chk("tx_idle_line", tx_a, 1'b1);
        chk("tx_busy_after", tx_busy_a, 1'b0);
    endtask

    typedef struct {
        bit         sel;
        logic [7:0] d;
        bit         has_par;
        bit         pbit;
        bit         stop;
        int         done;
        int         ferr;
        int         perr;
        int         cnt;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] wb[6];

    initial begin
        int sd, sf, sp, so;

        vecs[0] = '{0, 8'h30, 0, 0, 1, 1, 0, 0, 1};
        vecs[1] = '{0, 8'h31, 0, 0, 1, 1, 0, 0, 2};
        vecs[2] = '{0, 8'h32, 0, 0, 1, 1, 0, 0, 3};
        vecs[3] = '{1, 8'h31, 1, 0, 1, 0, 0, 1, 0};  // wrong even parity
        vecs[4] = '{1, 8'h30, 1, 0, 0, 0, 1, 0, 0};  // low stop bit
        vecs[5] = '{1, 8'h30, 1, 1, 0, 0, 1, 0, 0};  // both errors: frame only
        vecs[6] = '{1, 8'h31, 1, 1, 1, 1, 0, 0, 1};
        vecs[7] = '{1, 8'h00, 1, 0, 1, 1, 0, 0, 2};
        wb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_a", tx_a, 1'b1);
        chk("rst_tx_b", tx_b, 1'b1);
        chk("rst_rx_empty_a", rx_empty_a, 1'b1);
        chk("rst_rx_empty_b", rx_empty_b, 1'b1);
        chk("rst_rx_count_a", rx_count_a, 0);
        chk("rst_tx_count_b", tx_count_b, 0);
        chk("rst_tx_full_a", tx_full_a, 1'b0);
        chk("rst_tx_full_b", tx_full_b, 1'b0);
        chk("rst_tx_busy_a", tx_busy_a, 1'b0);
        chk("rst_tx_busy_b", tx_busy_b, 1'b0);
        chk("rst_pulses_a", {rx_done_a, frame_err_a, parity_err_a, overflow_a}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // table-driven receive frames
        for (int i = 0; i < 8; i++) begin
            sd = vecs[i].sel ? n_done_b : n_done_a;
            sf = vecs[i].sel ? n_ferr_b : n_ferr_a;
            sp = vecs[i].sel ? n_perr_b : n_perr_a;
            send_frame(vecs[i].sel, vecs[i].d, vecs[i].has_par, vecs[i].pbit, vecs[i].stop);
            chk("vec_rx_done",    (vecs[i].sel ? n_done_b : n_done_a) - sd, vecs[i].done);
            chk("vec_frame_err",  (vecs[i].sel ? n_ferr_b : n_ferr_a) - sf, vecs[i].ferr);
            chk("vec_parity_err", (vecs[i].sel ? n_perr_b : n_perr_a) - sp, vecs[i].perr);
            chk("vec_rx_count",   vecs[i].sel ? 32'(rx_count_b) : 32'(rx_count_a), vecs[i].cnt);
        end
        chk("b_head", rx_data_b, 8'h31);
        chk("b_no_overflow", n_ovf_b, 0);

        // FIFO read-out in order
        pop_a(8'h30);
        pop_a(8'h31);
        pop_a(8'h32);
        @(negedge clk);
        chk("rx_empty_after_reads", rx_empty_a, 1'b1);
        chk("rx_count_after_reads", rx_count_a, 0);

        // overflow on the fifth byte into a 4-deep FIFO
        for (int i = 0; i < 5; i++) begin
            so = n_ovf_a;
            send_frame(0, 8'hA0 + 8'(i), 0, 0, 1);
            chk("ovf_rx_count", rx_count_a, (i < 4) ? i + 1 : 4);
            chk("ovf_pulse", n_ovf_a - so, (i == 4) ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) pop_a(8'hA0 + 8'(i));
        @(negedge clk);
        chk("rx_empty_after_ovf", rx_empty_a, 1'b1);

        // loopback: host writes ignored, received byte echoed on tx
        loopback_a = 1'b1;
        @(negedge clk);
        tx_wr_a = 1'b1;
        tx_wdata_a = 8'h99;
        @(negedge clk);
        tx_wr_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("lb_host_wr_count", tx_count_a, 0);
        chk("lb_host_wr_busy", tx_busy_a, 1'b0);
        sd = n_done_a;
        fork
            send_frame(0, 8'h55, 0, 0, 1);
            check_tx(1, 64'h55, 0, 0);
        join
        chk("lb_rx_done", n_done_a - sd, 1);
        chk("lb_rx_count", rx_count_a, 0);
        loopback_a = 1'b0;
        repeat (10) @(negedge clk);

        // host writes fill the TX FIFO; frames go out back-to-back
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    tx_wr_a = 1'b1;
                    tx_wdata_a = wb[i];
                end
                @(negedge clk);
                tx_wr_a = 1'b0;
                chk("tx_full_set", tx_full_a, 1'b1);
                chk("tx_count_full", tx_count_a, 4);
            end
            check_tx(5, 64'h0000_0055_4433_2211, 1, 4);
        join
        chk("tx_count_drained", tx_count_a, 0);
        chk("tx_full_clear", tx_full_a, 1'b0);

        // short rx glitch rejected in START
        sd = n_done_a;
        sf = n_ferr_a;
        @(negedge clk);
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        repeat (2*BIT) @(negedge clk);
        chk("glitch_no_done", n_done_a - sd, 0);
        chk("glitch_no_ferr", n_ferr_a - sf, 0);
        chk("glitch_rx_count", rx_count_a, 0);

        // asynchronous reset in the middle of a TX data bit and an RX frame
        sd = n_done_a;
        sf = n_ferr_a;
        sp = n_perr_a;
        so = n_ovf_a;
        fork
            send_frame(0, 8'hFF, 0, 0, 1);
            begin
                @(negedge clk);
                tx_wr_a = 1'b1;
                tx_wdata_a = 8'h00;
                @(negedge clk);
                tx_wr_a = 1'b0;
                repeat (300) @(posedge clk);
                @(negedge clk);
                chk("pre_rst_tx_low", tx_a, 1'b0);
                #2 rst = 1'b1;
                #1;
                chk("rst_mid_tx_high", tx_a, 1'b1);
                chk("rst_mid_tx_busy", tx_busy_a, 1'b0);
                chk("rst_mid_tx_count", tx_count_a, 0);
                chk("rst_mid_rx_count", rx_count_a, 0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
        join
        chk("rst_mid_no_pulses", (n_done_a - sd) + (n_ferr_a - sf) + (n_perr_a - sp) + (n_ovf_a - so), 0);
        chk("rst_mid_tx_idle", tx_a, 1'b1);
        sd = n_done_a;
        send_frame(0, 8'h7E, 0, 0, 1);
        chk("post_rst_done", n_done_a - sd, 1);
        chk("post_rst_count", rx_count_a, 1);
        pop_a(8'h7E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end
endmodule
